// File: rtl/cbfp_exp_compensate.sv
// ---------------------------------------------------------------------------
// cbfp_exp_compensate
//
// Undoes the stage-0 CBFP normalisation on the output side. The normaliser
// emits one (re,im) shift pair for each 64-sample block. Those pairs wait in a
// small FIFO until the matching data block comes out of the downstream stages.
// One data block is 16 lanes x BEATS_PER_BLOCK beats. Each lane is then scaled
// back to OUT_WIDTH by 2^(SHIFT_BIAS - shift).
//
// Ports
//   clk, rstn               clock, asynchronous active-low reset
//   exp_valid/exp_re/exp_im push one exponent pair into the FIFO
//   exp_ready               FIFO not full
//   din_valid/din_real/imag one beat of 16 normalised lanes
//   dout_valid/dout_real/imag
//                           restored beat, one cycle after the input beat
//   fifo_level              number of exponent pairs currently held
//   err_ovf                 sticky: a pair was pushed while the FIFO was full
//   err_unf                 sticky: a block started while the FIFO was empty
// ---------------------------------------------------------------------------
module cbfp_exp_compensate #(
    parameter int IN_WIDTH        = 11,
    parameter int OUT_WIDTH       = 23,
    parameter int SHIFT_WIDTH     = 5,
    parameter int SHIFT_BIAS      = 12,
    parameter int BEATS_PER_BLOCK = 4,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        exp_valid,
    input  logic [SHIFT_WIDTH-1:0]      exp_re,
    input  logic [SHIFT_WIDTH-1:0]      exp_im,
    output logic                        exp_ready,
    input  logic                        din_valid,
    input  logic signed [IN_WIDTH-1:0]  din_real [0:15],
    input  logic signed [IN_WIDTH-1:0]  din_imag [0:15],
    output logic                        dout_valid,
    output logic signed [OUT_WIDTH-1:0] dout_real [0:15],
    output logic signed [OUT_WIDTH-1:0] dout_imag [0:15],
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err_ovf,
    output logic                        err_unf
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int BW   = (BEATS_PER_BLOCK > 1) ? $clog2(BEATS_PER_BLOCK) : 1;
    // The intermediate width has to hold the largest left shift of an input
    // sample. It must also be wider than the output, so saturation can be
    // detected before the result is truncated.
    localparam int WIDE = ((IN_WIDTH + SHIFT_BIAS > OUT_WIDTH) ? IN_WIDTH + SHIFT_BIAS : OUT_WIDTH) + 2;

    localparam logic [SHIFT_WIDTH-1:0] BIAS_S    = SHIFT_WIDTH'(SHIFT_BIAS);
    localparam logic [AW:0]            DEPTH_L   = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0]          LAST_BEAT = BW'(BEATS_PER_BLOCK - 1);
    localparam logic signed [WIDE-1:0] SAT_MAX   = {{(WIDE-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [WIDE-1:0] SAT_MIN   = {{(WIDE-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                 state_q, next_state;
    logic [BW-1:0]          beat_cnt_q, next_beat;
    logic                   block_start;

    logic [SHIFT_WIDTH-1:0] fifo_re [FIFO_DEPTH];
    logic [SHIFT_WIDTH-1:0] fifo_im [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            level_q;
    logic                   fifo_full, fifo_empty, push, pop;

    logic [SHIFT_WIDTH-1:0] head_re, head_im;
    logic [SHIFT_WIDTH-1:0] act_re_q, act_im_q;
    logic [SHIFT_WIDTH-1:0] use_re, use_im;

    // Rescales one lane by 2^(SHIFT_BIAS - sh).
    // A left shift saturates to the OUT_WIDTH range.
    // A right shift is arithmetic, so it floors; very large shifts leave
    // only the sign (0 or -1).
    function automatic logic signed [OUT_WIDTH-1:0] rescale(
        input logic signed [IN_WIDTH-1:0] x,
        input logic [SHIFT_WIDTH-1:0]     sh
    );
        logic signed [WIDE-1:0] ext;
        logic signed [WIDE-1:0] res;
        ext = {{(WIDE-IN_WIDTH){x[IN_WIDTH-1]}}, x};
        if (sh <= BIAS_S) begin
            res = ext <<< (BIAS_S - sh);
            if (res > SAT_MAX) begin
                res = SAT_MAX;
            end else if (res < SAT_MIN) begin
                res = SAT_MIN;
            end
        end else begin
            res = ext >>> (sh - BIAS_S);
        end
        return res[OUT_WIDTH-1:0];
    endfunction

    assign fifo_full  = (level_q == DEPTH_L);
    assign fifo_empty = (level_q == '0);
    assign exp_ready  = !fifo_full;
    assign fifo_level = level_q;

    // A pop happens only at the start of a block.
    // A push into a full FIFO is accepted only when a pop in the same cycle
    // frees the slot.
    // There is deliberately no empty bypass: a pair arriving together with
    // its own beat 0 does not count.
    assign pop  = block_start && !fifo_empty;
    assign push = exp_valid && (!fifo_full || pop);

    // When the FIFO is empty at a block start, the head reads as unity gain.
    // That value is latched for the whole block.
    assign head_re = fifo_empty ? BIAS_S : fifo_re[rd_ptr_q];
    assign head_im = fifo_empty ? BIAS_S : fifo_im[rd_ptr_q];

    // Beat 0 uses the FIFO head directly; later beats use the latched pair.
    assign use_re = (state_q == IDLE) ? head_re : act_re_q;
    assign use_im = (state_q == IDLE) ? head_im : act_im_q;

    // Block sequencer.
    // The FSM is in IDLE while it waits for beat 0.
    // It is in ACTIVE for the remaining beats.
    // Gaps in din_valid leave the state unchanged.
    always_comb begin
        next_state  = state_q;
        next_beat   = beat_cnt_q;
        block_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    block_start = 1'b1;
                    if (BEATS_PER_BLOCK == 1) begin
                        next_beat  = '0;
                        next_state = IDLE;
                    end else begin
                        next_beat  = BW'(1);
                        next_state = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (din_valid) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        next_beat  = '0;
                        next_state = IDLE;
                    end else begin
                        next_beat = beat_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                next_beat  = '0;
                next_state = IDLE;
            end
        endcase
    end

    // State register and beat counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= next_state;
            beat_cnt_q <= next_beat;
        end
    end

    // Exponent FIFO storage. No reset is needed here, because level_q
    // decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_re[wr_ptr_q] <= exp_re;
            fifo_im[wr_ptr_q] <= exp_im;
        end
    end

    // FIFO pointers, fill level and the sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_ovf  <= 1'b0;
            err_unf  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
            if (exp_valid && fifo_full && !pop) begin
                err_ovf <= 1'b1;
            end
            if (block_start && fifo_empty) begin
                err_unf <= 1'b1;
            end
        end
    end

    // Latch the exponent pair that applies to the rest of the block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_re_q <= BIAS_S;
            act_im_q <= BIAS_S;
        end else if (block_start) begin
            act_re_q <= head_re;
            act_im_q <= head_im;
        end
    end

    // Registered output stage. The data outputs keep their last value
    // between valid beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_valid <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                dout_real[i] <= '0;
                dout_imag[i] <= '0;
            end
        end else begin
            dout_valid <= din_valid;
            if (din_valid) begin
                for (int i = 0; i < 16; i++) begin
                    dout_real[i] <= rescale(din_real[i], use_re);
                    dout_imag[i] <= rescale(din_imag[i], use_im);
                end
            end
        end
    end

endmodule
